// File: rtl/data_memory_pkg.sv
// Shared types for the data-memory write path: entry layout, width codes and drain states.
// Entry fields are sized by the package constants; the module parameters default to them.
package data_memory_pkg;

    localparam int STORE_BUFFER_DEPTH      = 4;
    localparam int STORE_BUFFER_XLEN       = 32;
    localparam int STORE_BUFFER_PORT_WIDTH = 32;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } store_width_t;

    typedef struct packed {
        logic [STORE_BUFFER_XLEN-1:0]       address;
        logic [STORE_BUFFER_PORT_WIDTH-1:0] data;
        store_width_t                       width;
        logic                               valid;
    } store_buffer_entry_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_REQUEST,
        DRAIN_WAIT_DONE
    } drain_state_t;

endpackage

// File: rtl/store_buffer_match.sv
// Combinational address search over the buffer, walking oldest to youngest so the youngest hit wins.
// Zero latency; returns zero data when nothing matches.
module store_buffer_match
    import data_memory_pkg::*;
#(
    parameter int DEPTH      = STORE_BUFFER_DEPTH,
    parameter int XLEN       = STORE_BUFFER_XLEN,
    parameter int PORT_WIDTH = STORE_BUFFER_PORT_WIDTH
) (
    input  store_buffer_entry_t       i_entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]  i_head,
    input  logic [XLEN-1:0]           i_lookup_address,
    output logic                      o_match,
    output logic [PORT_WIDTH-1:0]     o_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_match = 1'b0;
        o_data  = '0;
        w_idx   = i_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PTR_W'(k);
            if (i_entries[w_idx].valid && (i_entries[w_idx].address == i_lookup_address)) begin
                o_match = 1'b1;
                o_data  = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/data_store_buffer.sv
// Write-posting FIFO between store/writeback sources and external memory, drained oldest-first.
// Push-to-request takes 3 cycles; pushes while full are dropped and the source must hold its request.
module data_store_buffer
    import data_memory_pkg::*;
#(
    parameter int DEPTH      = STORE_BUFFER_DEPTH,
    parameter int XLEN       = STORE_BUFFER_XLEN,
    parameter int PORT_WIDTH = STORE_BUFFER_PORT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  store_push_i,
    input  logic [XLEN-1:0]       store_address_i,
    input  logic [PORT_WIDTH-1:0] store_data_i,
    input  logic [1:0]            store_width_i,
    input  logic                  wb_push_i,
    input  logic [XLEN-1:0]       wb_address_i,
    input  logic [PORT_WIDTH-1:0] wb_data_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  port_idle_o,
    input  logic [XLEN-1:0]       lookup_address_i,
    output logic                  address_match_o,
    output logic [PORT_WIDTH-1:0] match_data_o,
    output logic                  mem_request_o,
    output logic [XLEN-1:0]       mem_address_o,
    output logic [PORT_WIDTH-1:0] mem_data_o,
    output logic [1:0]            mem_width_o,
    input  logic                  mem_acknowledge_i,
    input  logic                  mem_done_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    store_buffer_entry_t r_entries [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [CNT_W-1:0]    r_count;
    logic                r_full;
    logic                r_empty;
    drain_state_t        r_state;

    drain_state_t        w_state_next;
    store_buffer_entry_t w_new_entry;
    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_count_next;

    assign full_o      = r_full;
    assign empty_o     = r_empty;
    assign port_idle_o = !store_push_i;

    // Stores win the shared write port; a writeback only gets in on a cycle with no store.
    always_comb begin
        w_push              = (store_push_i | (wb_push_i & port_idle_o)) & !r_full;
        w_new_entry.valid   = 1'b1;
        w_new_entry.address = store_push_i ? store_address_i : wb_address_i;
        w_new_entry.data    = store_push_i ? store_data_i    : wb_data_i;
        w_new_entry.width   = store_push_i ? store_width_t'(store_width_i) : WORD;
    end

    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_comb begin
        w_state_next  = r_state;
        w_pop         = 1'b0;
        mem_request_o = 1'b0;
        mem_address_o = '0;
        mem_data_o    = '0;
        mem_width_o   = '0;
        case (r_state)
            DRAIN_IDLE: begin
                if (!r_empty) begin
                    w_state_next = DRAIN_REQUEST;
                end
            end
            DRAIN_REQUEST: begin
                mem_request_o = 1'b1;
                mem_address_o = r_entries[r_head].address;
                mem_data_o    = r_entries[r_head].data;
                mem_width_o   = r_entries[r_head].width;
                if (mem_acknowledge_i) begin
                    w_state_next = DRAIN_WAIT_DONE;
                end
            end
            DRAIN_WAIT_DONE: begin
                mem_address_o = r_entries[r_head].address;
                mem_data_o    = r_entries[r_head].data;
                mem_width_o   = r_entries[r_head].width;
                if (mem_done_i) begin
                    w_pop        = 1'b1;
                    // A push landing this cycle sits right behind the head, so it counts as remaining.
                    w_state_next = ((r_count > CNT_W'(1)) || w_push) ? DRAIN_REQUEST : DRAIN_IDLE;
                end
            end
            default: w_state_next = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_state <= DRAIN_IDLE;
        end else begin
            if (w_push) begin
                r_entries[r_tail] <= w_new_entry;
                r_tail            <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
            r_state <= w_state_next;
        end
    end

    store_buffer_match #(
        .DEPTH      (DEPTH),
        .XLEN       (XLEN),
        .PORT_WIDTH (PORT_WIDTH)
    ) u_match (
        .i_entries        (r_entries),
        .i_head           (r_head),
        .i_lookup_address (lookup_address_i),
        .o_match          (address_match_o),
        .o_data           (match_data_o)
    );

endmodule

// File: tb/tb_data_store_buffer.sv
// Bench for data_store_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_data_store_buffer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        store_push_i, wb_push_i;
    logic [31:0] store_address_i, store_data_i, wb_address_i, wb_data_i, lookup_address_i;
    logic [1:0]  store_width_i;
    logic        full_o, empty_o, port_idle_o, address_match_o;
    logic [31:0] match_data_o, mem_address_o, mem_data_o;
    logic        mem_request_o;
    logic [1:0]  mem_width_o;
    logic        mem_acknowledge_i, mem_done_i;

    always #5 clk_i = ~clk_i;

    data_store_buffer #(.DEPTH(DEPTH), .XLEN(32), .PORT_WIDTH(32)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .store_push_i      (store_push_i),
        .store_address_i   (store_address_i),
        .store_data_i      (store_data_i),
        .store_width_i     (store_width_i),
        .wb_push_i         (wb_push_i),
        .wb_address_i      (wb_address_i),
        .wb_data_i         (wb_data_i),
        .full_o            (full_o),
        .empty_o           (empty_o),
        .port_idle_o       (port_idle_o),
        .lookup_address_i  (lookup_address_i),
        .address_match_o   (address_match_o),
        .match_data_o      (match_data_o),
        .mem_request_o     (mem_request_o),
        .mem_address_o     (mem_address_o),
        .mem_data_o        (mem_data_o),
        .mem_width_o       (mem_width_o),
        .mem_acknowledge_i (mem_acknowledge_i),
        .mem_done_i        (mem_done_i)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  w;
    } ent_t;

    ent_t        q[$];       // buffered writes, oldest first
    logic [31:0] got_q[$];   // addresses the DUT presented when memory acknowledged
    bit          pend;       // a write has been acknowledged and awaits done
    bit          last_req;
    int          idle_wait;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic ref_lookup(input logic [31:0] la, output logic m, output logic [31:0] d);
        m = 1'b0;
        d = '0;
        foreach (q[i]) begin
            if (q[i].a == la) begin
                m = 1'b1;
                d = q[i].d;
            end
        end
    endtask

    // One clock: drive at the falling edge, check everything, then advance the model at the rising edge.
    task automatic cycle(input logic sp, input logic [31:0] sa, input logic [31:0] sd, input logic [1:0] sw,
                         input logic wp, input logic [31:0] wa, input logic [31:0] wd,
                         input logic ack, input logic done, input logic [31:0] la);
        logic        em;
        logic [31:0] ed;
        logic [31:0] addr_s;
        bit          req;
        bit          full_pre;
        store_push_i = sp; store_address_i = sa; store_data_i = sd; store_width_i = sw;
        wb_push_i = wp; wb_address_i = wa; wb_data_i = wd;
        mem_acknowledge_i = ack; mem_done_i = done; lookup_address_i = la;
        #1;
        ref_lookup(la, em, ed);
        req    = mem_request_o;
        addr_s = mem_address_o;
        chk("full", full_o, q.size() == DEPTH);
        chk("empty", empty_o, q.size() == 0);
        chk("port_idle", port_idle_o, !sp);
        chk("match", address_match_o, em);
        chk("match_data", match_data_o, ed);
        if (q.size() == 0) begin
            idle_wait = 0;
            chk("idle_req", req, 0);
            chk("idle_addr", mem_address_o, 0);
            chk("idle_data", mem_data_o, 0);
            chk("idle_width", mem_width_o, 0);
        end else begin
            if (pend) chk("req_after_ack", req, 0);
            if (pend || req) begin
                chk("bus_addr", mem_address_o, q[0].a);
                chk("bus_data", mem_data_o, q[0].d);
                chk("bus_width", mem_width_o, q[0].w);
            end
            idle_wait = (!pend && !req) ? idle_wait + 1 : 0;
            chk("drain_start", idle_wait <= 1, 1);
        end
        last_req = req;
        full_pre = (q.size() >= DEPTH);
        @(posedge clk_i);
        if (req && ack) begin
            pend = 1'b1;
            got_q.push_back(addr_s);
        end else if (pend && done) begin
            void'(q.pop_front());
            pend = 1'b0;
        end
        if (!full_pre) begin
            if (sp) q.push_back('{a: sa, d: sd, w: sw});
            else if (wp) q.push_back('{a: wa, d: wd, w: 2'd2});
        end
        @(negedge clk_i);
    endtask

    task automatic idle(input logic ack, input logic done);
        cycle(0, 0, 0, 0, 0, 0, 0, ack, done, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && (q.size() > 0 || !empty_o); n++) idle(1, 1);
        chk("drain_bound", q.size(), 0);
    endtask

    task automatic probe(input string tag, input logic [31:0] la, input logic m, input logic [31:0] d);
        lookup_address_i = la;
        #1;
        chk({tag, "_m"}, address_match_o, m);
        chk({tag, "_d"}, match_data_o, d);
    endtask

    initial begin
        int          n;
        logic [31:0] exp_addr [4];
        rst_i = 1'b1;
        store_push_i = 0; store_address_i = 0; store_data_i = 0; store_width_i = 0;
        wb_push_i = 0; wb_address_i = 0; wb_data_i = 0; lookup_address_i = 0;
        mem_acknowledge_i = 0; mem_done_i = 0;
        pend = 0; idle_wait = 0; last_req = 0;
        #2;
        chk("rst_empty", empty_o, 1);
        chk("rst_full", full_o, 0);
        chk("rst_req", mem_request_o, 0);
        chk("rst_match", address_match_o, 0);
        chk("rst_match_data", match_data_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Single store: request appears in the third cycle counting the push cycle.
        cycle(1, 32'h1000, 32'hDEADBEEF, 2'd2, 0, 0, 0, 0, 0, 0);
        n = 1;
        do begin
            n++;
            idle(0, 0);
        end while (!last_req && n < 8);
        chk("req_latency", n, 3);
        chk("req_addr", mem_address_o, 32'h1000);
        chk("req_data", mem_data_o, 32'hDEADBEEF);
        chk("req_width", mem_width_o, 2);
        idle(1, 0);
        idle(0, 1);
        idle(0, 0);
        chk("single_empty", empty_o, 1);

        // Fill to full, drop a fifth push, drain in order.
        got_q.delete();
        exp_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
        for (int i = 0; i < 4; i++) cycle(1, exp_addr[i], 32'hA0 + i, 2'(i % 3), 0, 0, 0, 0, 0, 0);
        chk("full_after4", full_o, 1);
        cycle(1, 32'h2000, 32'h55, 2'd2, 0, 0, 0, 0, 0, 0);
        probe("dropped", 32'h2000, 0, 0);
        drain();
        chk("drain_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("drain_order", got_q[i], exp_addr[i]);

        // Store and writeback together: only the store gets in; the held writeback follows.
        cycle(1, 32'h3000, 32'hA, 2'd0, 1, 32'h3004, 32'hB, 0, 0, 0);
        probe("wb_blocked", 32'h3004, 0, 0);
        probe("store_in", 32'h3000, 1, 32'hA);
        cycle(0, 0, 0, 0, 1, 32'h3004, 32'hB, 0, 0, 0);
        probe("wb_in", 32'h3004, 1, 32'hB);
        drain();

        // Youngest of two same-address entries wins.
        cycle(1, 32'h40, 32'h11111111, 2'd2, 0, 0, 0, 0, 0, 0);
        cycle(1, 32'h40, 32'h22222222, 2'd2, 0, 0, 0, 0, 0, 0);
        probe("youngest", 32'h40, 1, 32'h22222222);
        probe("miss", 32'h44, 0, 0);
        drain();

        // Reset while waiting for done.
        cycle(1, 32'h500, 32'h5, 2'd2, 0, 0, 0, 0, 0, 0);
        cycle(1, 32'h504, 32'h6, 2'd2, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6 && !pend; i++) idle(1, 0);
        chk("wait_done_reached", pend, 1);
        rst_i = 1'b1;
        lookup_address_i = 32'h500;
        #1;
        chk("mid_rst_empty", empty_o, 1);
        chk("mid_rst_req", mem_request_o, 0);
        chk("mid_rst_full", full_o, 0);
        chk("mid_rst_match", address_match_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        q.delete();
        pend = 0;
        idle_wait = 0;
        idle(0, 1);
        idle(0, 0);
        chk("late_done_empty", empty_o, 1);
        chk("late_done_req", mem_request_o, 0);

        // Random traffic on a small address set so lookups hit often.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 2) == 0, 32'h100 + 4 * $urandom_range(0, 7), $urandom, 2'($urandom_range(0, 2)),
                  $urandom_range(0, 1) == 1, 32'h100 + 4 * $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 32'h100 + 4 * $urandom_range(0, 8));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
